// File: rtl/cla_seq_ctrl_if.sv
// Operand/result handshake bus plus the shared 4-bit CLA slice connection.
// The slave side is the sequencer; the master side is its environment.
interface cla_seq_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
    logic             busy;
    logic [3:0]       cla_a;
    logic [3:0]       cla_b;
    logic             cla_cin;
    logic [3:0]       cla_sum;
    logic             cla_cout;

    modport slave (
        input  in_valid, a, b, cin, out_ready, cla_sum, cla_cout,
        output in_ready, out_valid, sum, cout, overflow, busy, cla_a, cla_b, cla_cin
    );

    modport master (
        output in_valid, a, b, cin, out_ready, cla_sum, cla_cout,
        input  in_ready, out_valid, sum, cout, overflow, busy, cla_a, cla_b, cla_cin
    );
endinterface

// File: rtl/cla_seq_ctrl.sv
// WIDTH-bit adder sequencer that time-multiplexes one external 4-bit CLA slice,
// least-significant nibble first, with the inter-nibble carry held in a flop.
module cla_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    cla_seq_ctrl_if.slave   io
);
    localparam int NSLICE = WIDTH / 4;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NSLICE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [IDXW-1:0]   idx_r;
    logic              carry_r;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic [WIDTH-1:0]  sum_r;
    logic              cout_r;
    logic              ovf_r;
    logic [IDXW+1:0]   shamt_s;

    // Bit offset of the active nibble: idx * 4.
    assign shamt_s = {idx_r, 2'b00};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (io.in_valid) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (idx_r == IDX_LAST) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                // Retiring takes priority; new operands wait for IDLE.
                if (io.out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output decode; the slice drive depends on registers only.
    always_comb begin
        io.in_ready  = 1'b0;
        io.out_valid = 1'b0;
        io.busy      = 1'b0;
        io.cla_a     = 4'd0;
        io.cla_b     = 4'd0;
        io.cla_cin   = 1'b0;
        io.sum       = sum_r;
        io.cout      = cout_r;
        io.overflow  = ovf_r;
        case (state_r)
            ST_IDLE: begin
                io.in_ready = rst_n;
            end
            ST_RUN: begin
                io.busy    = 1'b1;
                io.cla_a   = 4'(a_r >> shamt_s);
                io.cla_b   = 4'(b_r >> shamt_s);
                io.cla_cin = carry_r;
            end
            ST_DONE: begin
                io.busy      = 1'b1;
                io.out_valid = 1'b1;
            end
            default: begin
                io.in_ready = 1'b0;
            end
        endcase
    end

    // Operand capture, per-nibble accumulation and result flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r   <= '0;
            carry_r <= 1'b0;
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (io.in_valid) begin
                        a_r     <= io.a;
                        b_r     <= io.b;
                        carry_r <= io.cin;
                        idx_r   <= '0;
                        sum_r   <= '0;
                    end
                end
                ST_RUN: begin
                    sum_r   <= (sum_r & ~(WIDTH'(4'hF) << shamt_s))
                             | (WIDTH'(io.cla_sum) << shamt_s);
                    carry_r <= io.cla_cout;
                    if (idx_r == IDX_LAST) begin
                        // Top nibble: its slice outputs are the word's flags.
                        cout_r <= io.cla_cout;
                        ovf_r  <= (a_r[WIDTH-1] == b_r[WIDTH-1])
                               && (io.cla_sum[3] != a_r[WIDTH-1]);
                    end else begin
                        idx_r <= idx_r + IDXW'(1);
                    end
                end
                ST_DONE: begin
                    sum_r <= sum_r;
                end
                default: begin
                    idx_r <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cla_seq_ctrl.sv
// Directed bench for cla_seq_ctrl at WIDTH=16 with a behavioural CLA slice.
module tb_cla_seq_ctrl;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_miss;

    cla_seq_ctrl_if #(.WIDTH(16)) ifc ();

    cla_seq_ctrl #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (ifc.slave)
    );

    assign {ifc.cla_cout, ifc.cla_sum} = 5'(ifc.cla_a) + 5'(ifc.cla_b) + 5'(ifc.cla_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic [3:0]  cseq;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive operands at a falling edge and let the next rising edge accept them.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic cin);
        @(negedge clk);
        ifc.a        = a;
        ifc.b        = b;
        ifc.cin      = cin;
        ifc.in_valid = 1'b1;
        check("in_ready_idle", 32'(ifc.in_ready), 32'd1);
        @(posedge clk);
        #1 ifc.in_valid = 1'b0;
    endtask

    // Observe the RUN cycles and check the result once DONE is reached.
    task automatic finish_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] esum,
                             input logic ecout, input logic eovf, input logic [3:0] ecseq);
        logic [15:0] sa;
        logic [15:0] sb;
        logic [3:0]  sc;
        sa = 16'h0;
        sb = 16'h0;
        sc = 4'h0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("out_valid_run", 32'(ifc.out_valid), 32'd0);
            check("busy_run", 32'(ifc.busy), 32'd1);
            check("in_ready_run", 32'(ifc.in_ready), 32'd0);
            sa[4*k +: 4] = ifc.cla_a;
            sb[4*k +: 4] = ifc.cla_b;
            sc[k]        = ifc.cla_cin;
        end
        @(negedge clk);
        check("out_valid_done", 32'(ifc.out_valid), 32'd1);
        check("sum", 32'(ifc.sum), 32'(esum));
        check("cout", 32'(ifc.cout), 32'(ecout));
        check("overflow", 32'(ifc.overflow), 32'(eovf));
        check("cla_a_seq", 32'(sa), 32'(a));
        check("cla_b_seq", 32'(sb), 32'(b));
        check("cla_cin_seq", 32'(sc), 32'(ecseq));
        check("cla_a_done", 32'(ifc.cla_a), 32'd0);
    endtask

    task automatic retire();
        ifc.out_ready = 1'b1;
        @(posedge clk);
        #1 ifc.out_ready = 1'b0;
        @(negedge clk);
        check("out_valid_retired", 32'(ifc.out_valid), 32'd0);
        check("busy_retired", 32'(ifc.busy), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec  = 0;
        n_miss = 0;
        //              a         b         cin   sum       cout  ovf   cla_cin seq (bit k = nibble k)
        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 4'h0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 4'hE};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 4'hE};
        vecs[3] = '{16'h000F, 16'h0000, 1'b1, 16'h0010, 1'b0, 1'b0, 4'h3};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 4'h0};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 4'hF};
        vecs[6] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 4'h0};
        vecs[7] = '{16'h5555, 16'hAAAA, 1'b1, 16'h0000, 1'b1, 1'b0, 4'hF};
        vecs[8] = '{16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1, 4'h0};

        rst_n         = 1'b0;
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b0;
        ifc.a         = 16'h0;
        ifc.b         = 16'h0;
        ifc.cin       = 1'b0;
        #12;
        check("rst_in_ready", 32'(ifc.in_ready), 32'd0);
        check("rst_out_valid", 32'(ifc.out_valid), 32'd0);
        check("rst_busy", 32'(ifc.busy), 32'd0);
        check("rst_sum", 32'(ifc.sum), 32'd0);
        check("rst_cla_a", 32'(ifc.cla_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("in_ready_after_rst", 32'(ifc.in_ready), 32'd1);

        for (int i = 0; i < 9; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].cin);
            finish_op(vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].cout, vecs[i].ovf, vecs[i].cseq);
            retire();
        end

        // Backpressure in DONE with new operands already offered.
        start_op(16'h1234, 16'h4321, 1'b0);
        finish_op(16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 4'h0);
        ifc.a        = 16'h0001;
        ifc.b        = 16'h0002;
        ifc.cin      = 1'b0;
        ifc.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(ifc.out_valid), 32'd1);
            check("bp_in_ready", 32'(ifc.in_ready), 32'd0);
            check("bp_sum", 32'(ifc.sum), 32'h5555);
            check("bp_cout", 32'(ifc.cout), 32'd0);
            check("bp_overflow", 32'(ifc.overflow), 32'd0);
        end
        ifc.out_ready = 1'b1;
        @(posedge clk);
        #1 ifc.out_ready = 1'b0;
        @(negedge clk);
        check("bp_retire_out_valid", 32'(ifc.out_valid), 32'd0);
        check("bp_no_capture_busy", 32'(ifc.busy), 32'd0);
        check("bp_in_ready_idle", 32'(ifc.in_ready), 32'd1);
        @(posedge clk);
        #1 ifc.in_valid = 1'b0;
        finish_op(16'h0001, 16'h0002, 16'h0003, 1'b0, 1'b0, 4'h0);
        retire();

        // Asynchronous reset in the middle of RUN.
        start_op(16'h1234, 16'h4321, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_sum", 32'(ifc.sum), 32'd0);
        check("mid_rst_cout", 32'(ifc.cout), 32'd0);
        check("mid_rst_overflow", 32'(ifc.overflow), 32'd0);
        check("mid_rst_busy", 32'(ifc.busy), 32'd0);
        check("mid_rst_out_valid", 32'(ifc.out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(ifc.in_ready), 32'd0);
        check("mid_rst_cla", 32'({ifc.cla_a, ifc.cla_b, ifc.cla_cin}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("post_rst_in_ready", 32'(ifc.in_ready), 32'd1);
        start_op(16'h0001, 16'h0002, 1'b0);
        finish_op(16'h0001, 16'h0002, 16'h0003, 1'b0, 1'b0, 4'h0);
        retire();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/cla_seq_ctrl.md
# cla_seq_ctrl

Sequencer that performs a WIDTH-bit addition by time-multiplexing one shared external 4-bit carry-lookahead adder slice, least-significant nibble first. The carry between nibbles is held in an internal D flip-flop. The block sits between an operand producer and a result consumer, using valid/ready handshakes on both sides. It is the control layer that lets the 4-bit CLA datapath serve arbitrary word widths.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and ≥ 4; NSLICE = WIDTH/4
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand request
- in_ready  out  1  block can accept operands
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in for bit 0
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result; defined only while out_valid=1
- cout  out  1  carry out of bit WIDTH-1
- overflow  out  1  two's-complement signed overflow
- busy  out  1  high in RUN or DONE
- cla_a  out  4  nibble of A to shared CLA slice
- cla_b  out  4  nibble of B to shared CLA slice
- cla_cin  out  1  carry to CLA slice
- cla_sum  in  4  CLA slice sum (combinational from cla_a/b/cin)
- cla_cout  in  1  CLA slice carry-out

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: all registers, sum, cout, overflow, out_valid, busy and the cla_* outputs are 0. in_ready is 0 while rst_n=0 and 1 once in IDLE after rst_n=1.
- IDLE behaviour:
  - in_ready=1; cla_a, cla_b and cla_cin are driven 0.
  - When in_valid=1 at a rising edge: capture a, b and cin; idx←0; carry_ff←cin; sum←0; go to RUN.
- RUN behaviour, for each cycle:
  - Drive cla_a=a_reg[4*idx+3:4*idx], cla_b=b_reg[same bits], cla_cin=carry_ff.
  - At the edge: sum[4*idx+3:4*idx]←cla_sum, carry_ff←cla_cout, idx←idx+1.
- RUN exit (idx=NSLICE-1 at the edge):
  - cout←cla_cout.
  - overflow←(a_reg[W-1]==b_reg[W-1]) && (cla_sum[3]!=a_reg[W-1]).
  - Go to DONE.
- DONE behaviour:
  - out_valid=1; sum, cout and overflow hold stable.
  - When out_ready=1 at an edge: go to IDLE; out_valid←0.
- in_ready=0 in RUN and DONE. in_valid is ignored there and no operands are captured.
- idx is ceil(log2(NSLICE)) bits wide, min 1. It never wraps past NSLICE-1.
- Simultaneous in_valid and out_ready in DONE: only the result is retired. The new operands are accepted no earlier than the next cycle in IDLE.

## Timing
- Accept edge E0. RUN occupies the NSLICE cycles after E0. out_valid rises after edge E_NSLICE, i.e. 4 cycles for WIDTH=16.
- Result retires on the first edge with out_valid=1 and out_ready=1.
- Minimum initiation interval is NSLICE+2 cycles: accept, NSLICE RUN cycles, 1 DONE cycle, then IDLE.
- The cla_* outputs are combinational from registers only, with no combinational path from any input.
- The cla_sum/cla_cout to register path must close within one cycle.
- Asynchronous reset at any point, including mid-RUN or DONE:
  - All outputs and state return to reset values immediately.
  - The partial result is discarded.
  - The first edge after rst_n deasserts may accept new operands.

## Test plan
- Bench setup: WIDTH=16; the bench models the CLA slice as cla_sum/cla_cout = cla_a+cla_b+cla_cin.
- Basic add: a=0x1234, b=0x4321, cin=0 → sum=0x5555, cout=0, overflow=0. out_valid rises exactly 4 cycles after the accept edge. cla_a sequence is 4,3,2,1 and cla_b sequence is 1,2,3,4.
- Full carry ripple: a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, overflow=0. cla_cin is 0,1,1,1 across the RUN cycles.
- Signed overflow: a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, overflow=1. Also a=0x000F, b=0x0000, cin=1 → sum=0x0010, cout=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands.
  - sum, cout and overflow stay stable; in_ready=0; nothing is captured.
  - After out_ready=1, the next operands are accepted one cycle later and give correct results.
- Reset mid-operation: start 0x1234+0x4321, pull rst_n low after 2 RUN cycles.
  - All outputs read 0 immediately.
  - After release, in_ready=1, and 0x0001+0x0002 yields sum=0x0003 with no residue from the aborted operation.
